// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-add / radix-2 Booth multiplier with internal bit counter
module shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 St,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     Mcand,
    input  logic [WIDTH-1:0]     Mplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Idle,
    output logic                 Load,
    output logic                 Ad,
    output logic                 Sh,
    output logic                 Done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    cnt;
    logic             sgn;

    logic             need_cur;
    logic             sub_cur;
    logic             need_post;
    logic             last_bit;
    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_sh;
    logic [WIDTH-1:0] q_sh;

    // Unsigned adds on a 1 bit; Booth acts on a 0/1 boundary between current and previous bit.
    always_comb begin
        need_cur  = sgn ? (q[0] ^ qm1) : q[0];
        sub_cur   = sgn & q[0] & ~qm1;
        need_post = sgn ? (q[1] ^ q[0]) : q[1];
        last_bit  = (cnt == CW'(WIDTH - 1));
        a_sum     = sub_cur ? (a - m) : (a + m);
        a_sh      = {(sgn & a[WIDTH]), a[WIDTH:1]};
        q_sh      = {a[0], q[WIDTH-1:1]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = St ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = need_cur ? S_ADD : S_SHIFT;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (last_bit) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = need_post ? S_ADD : S_SHIFT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        Idle = (state == S_IDLE);
        Load = (state == S_LOAD);
        Ad   = (state == S_ADD);
        Sh   = (state == S_SHIFT);
        Done = (state == S_DONE);
    end

    // Product is captured from the post-shift value on the final shift, i.e. on DONE entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            sgn     <= 1'b0;
            Product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (St) begin
                        a   <= '0;
                        q   <= Mplier;
                        qm1 <= 1'b0;
                        cnt <= '0;
                        m   <= {(Signed_Mode & Mcand[WIDTH-1]), Mcand};
                        sgn <= Signed_Mode;
                    end
                end
                S_ADD: begin
                    a <= a_sum;
                end
                S_SHIFT: begin
                    a   <= a_sh;
                    q   <= q_sh;
                    qm1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        Product <= {a_sh[WIDTH-1:0], q_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential multiplier: the next generation of the shift-add multiplier controller. It merges the Idle/Load/Ad/Sh/Done control FSM with its datapath and generates the K (last-bit) condition internally from a bit counter instead of taking it as an input. It adds a per-operation signed mode using radix-2 Booth recoding. It sits beside the ALU in the MIPS CPU and serves multiply instructions.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 2.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- St  input  1  start request; sampled only in IDLE.
- Signed_Mode  input  1  0 = unsigned shift-add, 1 = two's-complement Booth; sampled with St.
- Mcand  input  WIDTH  multiplicand; sampled with St.
- Mplier  input  WIDTH  multiplier; sampled with St.
- Product  output  2*WIDTH  result register.
- Idle  output  1  FSM is in IDLE.
- Load  output  1  FSM is in LOAD.
- Ad  output  1  FSM is in ADD (add or subtract).
- Sh  output  1  FSM is in SHIFT.
- Done  output  1  FSM is in DONE; single-cycle pulse.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. All five status outputs are Moore-decoded from the state and are one-hot.
- Internal registers:
  - A: WIDTH+1 bits.
  - Q: WIDTH bits.
  - Qm1: 1 bit, Booth history.
  - M: WIDTH+1 bits, multiplicand, zero-extended (unsigned) or sign-extended (signed).
  - Cnt: clog2(WIDTH) bits.
  - Sgn: 1 bit, latched mode.
- IDLE -> LOAD when St=1. On that edge: A<=0, Q<=Mplier, Qm1<=0, Cnt<=0, M<=extended Mcand, Sgn<=Signed_Mode. St=0 stays in IDLE.
- Decision bit D, evaluated at LOAD and SHIFT exit:
  - Unsigned: add when the next-cycle Q[0]=1.
  - Signed: pair (next Q[0], next Qm1). 10 -> subtract, 01 -> add, 00 and 11 -> no operation.
- LOAD -> ADD if an operation is required, else LOAD -> SHIFT.
- ADD -> SHIFT always. In ADD, A <= A + M, or A - M for Booth 10; arithmetic is WIDTH+1 bits, modulo 2^(WIDTH+1).
- SHIFT: {A,Q,Qm1} shifts right one place; Q[0] goes into Qm1.
  - The incoming MSB of A is 0 when unsigned, A[WIDTH] when signed (arithmetic shift).
  - Cnt increments.
- SHIFT exit:
  - If Cnt == WIDTH-1 before the increment (internal K), go to DONE.
  - Otherwise go to ADD if an operation is required on the post-shift bits (pre-shift Q[1], Q[0]), else stay in SHIFT.
- On entering DONE: Product <= {A[WIDTH-1:0], Q}. DONE -> IDLE unconditionally.
- Product holds its value until the next DONE entry. It never changes during IDLE, LOAD, ADD or SHIFT.
- St outside IDLE is ignored and is not queued. St held high in IDLE restarts immediately after DONE -> IDLE.

## Timing
- Reset (asynchronous, Rst_n=0): state=IDLE, Idle=1, Load=Ad=Sh=Done=0, Product=0, A/Q/Qm1/M/Cnt/Sgn=0. Reset asserted mid-operation aborts it; no Done is issued.
- Latency, counted in states from LOAD to DONE inclusive: 1 + WIDTH + N_add + 1.
  - Unsigned: N_add = popcount(Mplier).
  - Signed: N_add = number of 01/10 pairs over Mplier bits with Qm1 initially 0.
- Product is valid on the first cycle Done=1 and stays valid until the next Done.
- IDLE with St=1 at edge t gives Load=1 during cycle t..t+1.

## Test plan
- Reset mid-run:
  - Stimulus: start 13*11, assert Rst_n=0 during SHIFT.
  - Response: Idle=1 and Product=0 immediately; no Done pulse.
  - Then start 13*11 unsigned.
  - Response: Product=143 (0x008F); Ad pulses 3 times; Done asserts exactly 13 cycles after Load is first observed.
- Unsigned extremes, WIDTH=8:
  - 255*255 -> Product=0xFE01 with 8 Ad cycles.
  - 0*0 -> Product=0 with 0 Ad cycles and Done 10 cycles after Load.
- Signed, WIDTH=8:
  - (-3)*5 -> 0xFFF1 with 4 Ad cycles and a latency of 14.
  - (-128)*(-128) -> 0x4000.
  - 127*(-1) -> 0xFF81.
- St pulsed during ADD/SHIFT with different operands:
  - Response: ignored; the original result completes; Product is unchanged until Done.
- St held high continuously:
  - Response: back-to-back operations; IDLE lasts exactly 1 cycle between Done and the next Load; each Product is correct.
- WIDTH=4 and WIDTH=16 instances:
  - WIDTH=4: signed 7*(-8) -> 0xC8.
  - WIDTH=16: unsigned 0xFFFF*0x0002 -> 0x0001FFFE; Sh pulses exactly WIDTH times per operation.
